// File: rtl/switch_bouncer_pkg.sv
// ============================================================================
// switch_bouncer_pkg : shared FSM state type and LFSR constants
// Revision: 1.0
// ============================================================================
`default_nettype none

package switch_bouncer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BOUNCE = 2'd1,
    ST_SETTLE = 2'd2
  } state_e;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // x^8+x^6+x^5+x^4+1 taken from bits 7,5,4,3 of a left-shifting register
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

`default_nettype wire

// File: rtl/switch_bouncer_lfsr8.sv
// ============================================================================
// lfsr8 : 8-bit Fibonacci LFSR that advances on en; built only with BOUNCE_LFSR_EN
// Revision: 1.0
// ============================================================================
`default_nettype none

`ifdef BOUNCE_LFSR_EN
module lfsr8
  import switch_bouncer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [7:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= LFSR_SEED;
    end else if (en) begin
      q <= lfsr_next(q);
    end
  end

endmodule
`endif

`default_nettype wire

// File: rtl/switch_bouncer.sv
// ============================================================================
// switch_bouncer : emulates a bouncing mechanical switch driven by a clean cmd.
// Optional macro BOUNCE_LFSR_EN selects pseudo-random gaps instead of GAP.
// Revision: 1.0
// ============================================================================
`default_nettype none

module switch_bouncer
  import switch_bouncer_pkg::*;
#(
  parameter int BOUNCES = 3,
  parameter int GAP     = 4,
  parameter int GAP_W   = 3,
  parameter int HOLD    = 8
)(
  input  logic clk,
  input  logic rst,
  input  logic cmd,
  output logic o,
  output logic busy,
  output logic done
);

  if (BOUNCES < 1 || BOUNCES > 15) begin : g_bad_bounces
    $error("switch_bouncer: BOUNCES must be 1..15");
  end
  if (GAP < 1 || GAP > 255) begin : g_bad_gap
    $error("switch_bouncer: GAP must be 1..255");
  end
  if (GAP_W < 1 || GAP_W > 7) begin : g_bad_gap_w
    $error("switch_bouncer: GAP_W must be 1..7");
  end
  if (HOLD < 1 || HOLD > 255) begin : g_bad_hold
    $error("switch_bouncer: HOLD must be 1..255");
  end

  localparam int TOG_W  = $clog2(2 * BOUNCES + 1);
  localparam int HOLD_W = $clog2(HOLD + 1);
`ifdef BOUNCE_LFSR_EN
  localparam int GAP_CW = GAP_W + 1;
`else
  localparam int GAP_CW = $clog2(GAP + 1);
`endif

  localparam logic [TOG_W-1:0]  TOG_INIT  = TOG_W'(2 * BOUNCES);
  localparam logic [TOG_W-1:0]  TOG_ONE   = TOG_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [GAP_CW-1:0] GAP_ONE   = GAP_CW'(1);

  state_e              r_state;
  logic                r_tgt;
  logic [TOG_W-1:0]    r_tog_cnt;
  logic [GAP_CW-1:0]   r_gap_cnt;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic [GAP_CW-1:0]   w_gap_load;

`ifdef BOUNCE_LFSR_EN
  localparam logic [7:0] GAP_MASK = 8'((1 << GAP_W) - 1);

  logic       w_gap_take;
  logic [7:0] w_lfsr_q;

  // Every gap value handed to the counter consumes one LFSR step; the final
  // toggle of a burst loads nothing, so it does not advance the sequence.
  assign w_gap_take = ((r_state == ST_IDLE) && (cmd != o)) ||
                      ((r_state == ST_BOUNCE) && (r_gap_cnt == GAP_ONE) &&
                       (r_tog_cnt != TOG_ONE));

  lfsr8 u_lfsr8 (
    .clk (clk),
    .rst (rst),
    .en  (w_gap_take),
    .q   (w_lfsr_q)
  );

  assign w_gap_load = GAP_CW'((w_lfsr_q & GAP_MASK) + 8'd1);
`else
  assign w_gap_load = GAP_CW'(GAP);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      o          <= 1'b0;
      r_tgt      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      r_tog_cnt  <= '0;
      r_gap_cnt  <= '0;
      r_hold_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cmd != o) begin
            r_tgt     <= cmd;
            o         <= cmd;
            r_tog_cnt <= TOG_INIT;
            r_gap_cnt <= w_gap_load;
            busy      <= 1'b1;
            r_state   <= ST_BOUNCE;
          end
        end
        ST_BOUNCE: begin
          if (r_gap_cnt == GAP_ONE) begin
            r_tog_cnt <= r_tog_cnt - TOG_ONE;
            if (r_tog_cnt == TOG_ONE) begin
              // Even toggle count: the last edge always lands on the target.
              o          <= r_tgt;
              r_gap_cnt  <= '0;
              r_hold_cnt <= HOLD_INIT;
              r_state    <= ST_SETTLE;
            end else begin
              o         <= ~o;
              r_gap_cnt <= w_gap_load;
            end
          end else begin
            r_gap_cnt <= r_gap_cnt - GAP_ONE;
          end
        end
        ST_SETTLE: begin
          if (r_hold_cnt == HOLD_ONE) begin
            r_hold_cnt <= '0;
            busy       <= 1'b0;
            done       <= 1'b1;
            r_state    <= ST_IDLE;
          end else begin
            r_hold_cnt <= r_hold_cnt - HOLD_ONE;
          end
        end
        default: begin
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_switch_bouncer.sv
// ============================================================================
// tb_switch_bouncer : self-checking bench for switch_bouncer (fixed and LFSR builds)
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_switch_bouncer;

  localparam int B     = 3;
  localparam int G     = 4;
  localparam int GW    = 3;
  localparam int H     = 8;
  localparam int T_TOG = 2 * B * G;
  localparam int T_END = T_TOG + H;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd = 1'b0;
  logic o;
  logic busy;
  logic done;

  int checks   = 0;
  int failures = 0;

  switch_bouncer #(
    .BOUNCES (B),
    .GAP     (G),
    .GAP_W   (GW),
    .HOLD    (H)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .cmd  (cmd),
    .o    (o),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cmd = 1'b0;
    tick();
    tick();
    checks++;
    if (o !== 1'b0) begin
      failures++;
      $display("FAIL reset_o: got %b want 0", o);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy: got %b want 0", busy);
    end
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL reset_done: got %b want 0", done);
    end
    rst = 1'b0;
  endtask

`ifndef BOUNCE_LFSR_EN
  // Timeline model: position k within a sequence determines everything.
  bit   m_active;
  int   m_k;
  logic m_tgt;
  logic m_o;
  logic m_done;

  task automatic model_reset();
    m_active = 1'b0;
    m_k      = 0;
    m_tgt    = 1'b0;
    m_o      = 1'b0;
    m_done   = 1'b0;
  endtask

  task automatic model_edge(input logic c);
    m_done = 1'b0;
    if (m_active) begin
      m_k++;
      if (m_k == T_END) begin
        m_active = 1'b0;
        m_done   = 1'b1;
      end
    end else if (c != m_o) begin
      m_active = 1'b1;
      m_k      = 0;
      m_tgt    = c;
    end
    if (m_active && m_k < T_TOG)
      m_o = m_tgt ^ logic'((m_k / G) % 2);
    else
      m_o = m_tgt;
  endtask

  task automatic step(input logic c);
    cmd = c;
    @(posedge clk);
    model_edge(c);
    #1;
  endtask

  task automatic test_basic();
    int   edges   = 0;
    int   done_at = -1;
    logic prev    = 1'b0;
    model_reset();
    for (int i = 0; i < 40; i++) begin
      step(1'b1);
      checks++;
      if (o !== m_o || busy !== m_active || done !== m_done) begin
        failures++;
        $display("FAIL basic i=%0d o=%b/%b busy=%b/%b done=%b/%b (got/want)",
                 i, o, m_o, busy, m_active, done, m_done);
      end
      if (o !== prev) edges++;
      prev = o;
      if (done === 1'b1) done_at = i;
    end
    checks++;
    if (edges != 7) begin
      failures++;
      $display("FAIL basic_edges: got %0d want 7", edges);
    end
    checks++;
    if (done_at != 32) begin
      failures++;
      $display("FAIL basic_done_at: got %0d want 32", done_at);
    end
    checks++;
    if (o !== 1'b1) begin
      failures++;
      $display("FAIL basic_final_o: got %b want 1", o);
    end
  endtask

  task automatic test_cmd_glitch();
    int   falls   = 0;
    int   fall_at = -1;
    int   edges   = 0;
    logic pbusy;
    logic prev;
    logic c;
    for (int i = 0; i < 40; i++) begin
      step(1'b0);
      checks++;
      if (o !== m_o || busy !== m_active || done !== m_done) begin
        failures++;
        $display("FAIL glitch_prep i=%0d o=%b/%b busy=%b/%b done=%b/%b (got/want)",
                 i, o, m_o, busy, m_active, done, m_done);
      end
    end
    pbusy = busy;
    prev  = o;
    for (int i = 0; i < 40; i++) begin
      c = (i == 3 || i == 4 || i == 10 || i == 17 || i == 18 || i == 19) ? 1'b0 : 1'b1;
      step(c);
      checks++;
      if (o !== m_o || busy !== m_active || done !== m_done) begin
        failures++;
        $display("FAIL glitch i=%0d o=%b/%b busy=%b/%b done=%b/%b (got/want)",
                 i, o, m_o, busy, m_active, done, m_done);
      end
      if (pbusy === 1'b1 && busy === 1'b0) begin
        falls++;
        fall_at = i;
      end
      if (o !== prev) edges++;
      pbusy = busy;
      prev  = o;
    end
    checks++;
    if (falls != 1 || fall_at != 32) begin
      failures++;
      $display("FAIL glitch_busy_fall: got falls=%0d at=%0d want 1 at 32", falls, fall_at);
    end
    checks++;
    if (edges != 7 || o !== 1'b1) begin
      failures++;
      $display("FAIL glitch_end: got edges=%0d o=%b want 7 and 1", edges, o);
    end
  endtask

  task automatic test_settle_restart();
    for (int i = 0; i < 40; i++) step(1'b0);
    for (int i = 0; i < 76; i++) begin
      step((i < 26) ? 1'b1 : 1'b0);
      checks++;
      if (o !== m_o || busy !== m_active || done !== m_done) begin
        failures++;
        $display("FAIL settle i=%0d o=%b/%b busy=%b/%b done=%b/%b (got/want)",
                 i, o, m_o, busy, m_active, done, m_done);
      end
      if (i == 33) begin
        checks++;
        if (o !== 1'b0 || busy !== 1'b1) begin
          failures++;
          $display("FAIL settle_restart: got o=%b busy=%b want 0 1", o, busy);
        end
      end
    end
    checks++;
    if (o !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL settle_final: got o=%b busy=%b want 0 0", o, busy);
    end
  endtask

  task automatic test_reset_mid();
    int   edges = 0;
    logic prev;
    for (int i = 0; i <= 10; i++) begin
      step(1'b1);
      checks++;
      if (o !== m_o || busy !== m_active) begin
        failures++;
        $display("FAIL rstmid_pre i=%0d o=%b/%b busy=%b/%b (got/want)",
                 i, o, m_o, busy, m_active);
      end
    end
    rst = 1'b1;
    #1;
    checks++;
    if (o !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_async: got o=%b busy=%b done=%b want 0 0 0", o, busy, done);
    end
    model_reset();
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (o !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL rstmid_hold i=%0d: got o=%b busy=%b want 0 0", i, o, busy);
      end
    end
    rst  = 1'b0;
    prev = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(1'b1);
      checks++;
      if (o !== m_o || busy !== m_active || done !== m_done) begin
        failures++;
        $display("FAIL rstmid_post i=%0d o=%b/%b busy=%b/%b done=%b/%b (got/want)",
                 i, o, m_o, busy, m_active, done, m_done);
      end
      if (o !== prev) edges++;
      prev = o;
    end
    checks++;
    if (edges != 7 || o !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_seq: got edges=%0d o=%b want 7 and 1", edges, o);
    end
  endtask

  task automatic test_random();
    logic rc = m_o;
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 9) == 0) rc = ~rc;
      step(rc);
      checks++;
      if (o !== m_o || busy !== m_active || done !== m_done) begin
        failures++;
        $display("FAIL random n=%0d o=%b/%b busy=%b/%b done=%b/%b (got/want)",
                 n, o, m_o, busy, m_active, done, m_done);
      end
    end
  endtask
`else
  function automatic logic [7:0] ref_next(input logic [7:0] s);
    // x^8+x^6+x^5+x^4+1
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  task automatic test_lfsr();
    int         exp_gaps[2*B];
    logic [7:0] ls = 8'hA5;
    logic       tgt_c = 1'b0;
    logic       prev;
    int         edges;
    int         last;
    int         gap;
    bit         fin;
    for (int i = 0; i < 2 * B; i++) begin
      exp_gaps[i] = 1 + int'(ls & 8'((1 << GW) - 1));
      ls = ref_next(ls);
    end
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int t = 0; t < 100; t++) begin
      tgt_c = ~tgt_c;
      cmd   = tgt_c;
      prev  = ~tgt_c;
      edges = 0;
      last  = 0;
      fin   = 1'b0;
      for (int c = 0; c < 200 && !fin; c++) begin
        if (c == 2) cmd = ~tgt_c;
        if (c == 3) cmd = tgt_c;
        tick();
        if (o !== prev) begin
          if (edges > 0) begin
            gap = c - last;
            checks++;
            if (gap < 1 || gap > (1 << GW)) begin
              failures++;
              $display("FAIL lfsr_gap_range t=%0d: got %0d want 1..%0d", t, gap, 1 << GW);
            end
            if (t == 0 && edges <= 2 * B) begin
              checks++;
              if (gap != exp_gaps[edges-1]) begin
                failures++;
                $display("FAIL lfsr_gap_value idx=%0d: got %0d want %0d",
                         edges - 1, gap, exp_gaps[edges-1]);
              end
            end
          end
          last = c;
          edges++;
          prev = o;
        end
        if (done === 1'b1) fin = 1'b1;
      end
      checks++;
      if (!fin) begin
        failures++;
        $display("FAIL lfsr_timeout t=%0d: got no done want done within 200 cycles", t);
      end
      checks++;
      if (edges != 2 * B + 1) begin
        failures++;
        $display("FAIL lfsr_edges t=%0d: got %0d want %0d", t, edges, 2 * B + 1);
      end
      checks++;
      if (o !== tgt_c) begin
        failures++;
        $display("FAIL lfsr_final t=%0d: got %b want %b", t, o, tgt_c);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef BOUNCE_LFSR_EN
    test_lfsr();
`else
    test_basic();
    test_cmd_glitch();
    test_settle_restart();
    test_reset_mid();
    test_random();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
